// File: rtl/trig_lut_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_lut_sequencer_pkg
//  Description : Shared encodings and constants for the trig LUT sequencer.
//                This covers the function select codes, the FSM state codes,
//                the angle landmarks and the IEEE-754 infinity patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
package trig_lut_sequencer_pkg;

    // Function select encodings
    localparam logic [1:0] FN_SIN  = 2'd0;
    localparam logic [1:0] FN_COS  = 2'd1;
    localparam logic [1:0] FN_TAN  = 2'd2;
    localparam logic [1:0] FN_RSVD = 2'd3;

    // Sequencer FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REDUCE = 3'd1;
    localparam logic [2:0] ST_FOLD   = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    // Angle landmarks in degrees
    localparam logic [8:0] DEG_90  = 9'd90;
    localparam logic [8:0] DEG_180 = 9'd180;
    localparam logic [8:0] DEG_270 = 9'd270;
    localparam logic [8:0] DEG_360 = 9'd360;

    // IEEE-754 double +/- infinity, returned for tan at its poles
    localparam logic [63:0] DBL_POS_INF = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] DBL_NEG_INF = 64'hFFF0_0000_0000_0000;

    // Returns 1 when the function is negative in the given quadrant.
    function automatic logic quadrant_negative(input logic [1:0] fn, input logic [1:0] q);
        case (fn)
            FN_SIN:  return q[1];
            FN_COS:  return q[1] ^ q[0];
            default: return q[0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/trig_lut_sequencer_angle_mod360.sv
`default_nettype none
// ============================================================================
//  Module      : angle_mod360
//  Description : Restoring modulo-360 reduction. A start pulse loads the
//                angle, and one compare/subtract of 360<<k is done per cycle
//                with k running from DATA_WIDTH-9 down to 0. The step count
//                is fixed and does not depend on the angle value.
//  Revision    : 1.0 - initial release
// ============================================================================
module angle_mod360
    import trig_lut_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] angle,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  done
);

    localparam int STEPS = DATA_WIDTH - 8;
    localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [DATA_WIDTH-1:0] c_modulus = DATA_WIDTH'(DEG_360);
    localparam logic [KW-1:0]         c_k_first = KW'(STEPS - 1);

    logic [KW-1:0]         r_k;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] w_sub;

    // 360 << k cannot overflow because 360 < 2^9 and k <= DATA_WIDTH-9
    assign w_sub     = c_modulus << r_k;
    assign remainder = r_rem;
    // High during the final step, so the caller can advance on the same edge
    assign done      = r_busy && (r_k == '0);

    // Load on start, then perform one conditional subtract per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k    <= '0;
            r_busy <= 1'b0;
            r_rem  <= '0;
        end else if (start) begin
            r_rem  <= angle;
            r_k    <= c_k_first;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_rem >= w_sub) begin
                r_rem <= r_rem - w_sub;
            end
            if (r_k == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_k <= r_k - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trig_lut_sequencer.sv
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`default_nettype none
// ============================================================================
//  Module      : trig_lut_sequencer
//  Description : Front end for the sin/cos/tan LUTs. It accepts one angle
//                request and reduces the angle mod 360. It then folds the
//                angle into 0..90 and fires one LUT enable. Finally it signs
//                the returned double by quadrant and hands the result back
//                over a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_lut_sequencer
    import trig_lut_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int LUT_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              func_sel,
    input  logic [DATA_WIDTH-1:0]   angle_in,
    output logic                    en_sine,
    output logic                    en_cosine,
    output logic                    en_tangent,
    output logic [1:0]              quadrant,
    output logic [DATA_WIDTH-1:0]   lut_angle,
    input  logic [2*DATA_WIDTH-1:0] lut_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [2*DATA_WIDTH-1:0] resp_data,
    output logic                    resp_err
);

    localparam logic [2:0] c_wait_last = 3'(LUT_LATENCY - 1);

    logic [2:0]              r_state;
    logic [1:0]              r_func;
    logic                    r_sign;
    logic [2:0]              r_wait_cnt;

    logic                    w_start;
    logic [DATA_WIDTH-1:0]   w_r;
    logic                    w_done;
    logic [1:0]              w_q;
    logic [DATA_WIDTH-1:0]   w_a;
    logic                    w_neg;
    logic                    w_singular;
    logic [2*DATA_WIDTH-2:0] w_mag;
    logic                    w_unused;

    // Reserved requests never need a reduction, so they do not start one
    assign w_start = (r_state == ST_IDLE) && req_valid && (func_sel != FN_RSVD);

    angle_mod360 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mod360 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (w_start),
        .angle     (angle_in),
        .remainder (w_r),
        .done      (w_done)
    );

    // Quadrant, folded angle and pole detection from the reduced angle
    always_comb begin
        w_q = 2'd0;
        w_a = w_r;
        if (w_r < DATA_WIDTH'(DEG_90)) begin
            w_q = 2'd0;
            w_a = w_r;
        end else if (w_r < DATA_WIDTH'(DEG_180)) begin
            w_q = 2'd1;
            w_a = DATA_WIDTH'(DEG_180) - w_r;
        end else if (w_r < DATA_WIDTH'(DEG_270)) begin
            w_q = 2'd2;
            w_a = w_r - DATA_WIDTH'(DEG_180);
        end else begin
            w_q = 2'd3;
            w_a = DATA_WIDTH'(DEG_360) - w_r;
        end
    end

    assign w_neg      = quadrant_negative(r_func, w_q);
    assign w_singular = (r_func == FN_TAN) &&
                        ((w_r == DATA_WIDTH'(DEG_90)) || (w_r == DATA_WIDTH'(DEG_270)));
    // The LUT sign bit is ignored; only its magnitude is used
    assign w_mag      = lut_data[2*DATA_WIDTH-2:0];
    assign w_unused   = lut_data[2*DATA_WIDTH-1];

    // Sequencer FSM with all handshake and LUT outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_func     <= FN_SIN;
            r_sign     <= 1'b0;
            r_wait_cnt <= 3'd0;
            req_ready  <= 1'b1;
            en_sine    <= 1'b0;
            en_cosine  <= 1'b0;
            en_tangent <= 1'b0;
            quadrant   <= 2'd0;
            lut_angle  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_func    <= func_sel;
                        if (func_sel == FN_RSVD) begin
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_state <= ST_REDUCE;
                        end
                    end
                end
                ST_REDUCE: begin
                    if (w_done) begin
                        r_state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    quadrant  <= w_q;
                    lut_angle <= w_a;
                    r_sign    <= w_neg;
                    if (w_singular) begin
                        resp_data  <= (w_r == DATA_WIDTH'(DEG_90)) ?
                                      (2*DATA_WIDTH)'(DBL_POS_INF) :
                                      (2*DATA_WIDTH)'(DBL_NEG_INF);
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        en_sine    <= (r_func == FN_SIN);
                        en_cosine  <= (r_func == FN_COS);
                        en_tangent <= (r_func == FN_TAN);
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    en_sine    <= 1'b0;
                    en_cosine  <= 1'b0;
                    en_tangent <= 1'b0;
                    r_wait_cnt <= 3'd0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        // Suppress negative zero
                        resp_data  <= {r_sign & (|w_mag), w_mag};
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        r_state    <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/trig_lut_sequencer.md
Name: trig_lut_sequencer

Overview:
- Front-end controller for the sine, cosine and tangent LUT blocks.
- Accepts one request at a time over a valid/ready handshake. A request is an integer angle in degrees of any magnitude plus a function select.
- Reduces the angle modulo 360, folds it into 0..90 and derives the quadrant. It then enables exactly one LUT for one cycle and captures the LUT magnitude.
- Applies the quadrant sign to IEEE-754 double bit 63 and returns the result over a valid/ready response handshake.

Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): angle width, taken from `src/defines.v`.
- `LUT_LATENCY`, default 1: rising edges from the end of the enable cycle until `lut_data` is valid (1..7).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer idle and able to accept.
- `func_sel`  in  2  function select: 0 sin, 1 cos, 2 tan, 3 reserved.
- `angle_in`  in  DATA_WIDTH  unsigned angle in degrees.
- `en_sine`, `en_cosine`, `en_tangent`  out  1 each  one-cycle LUT enables.
- `quadrant`  out  2  quadrant of the reduced angle, driven to the LUTs.
- `lut_angle`  out  DATA_WIDTH  folded angle 0..90, driven to the LUTs.
- `lut_data`  in  2*DATA_WIDTH  LUT result (double).
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  2*DATA_WIDTH  signed double result.
- `resp_err`  out  1  singular or illegal request.

Behaviour:
- **Reset values.** All outputs are 0 except `req_ready`, which is 1. The FSM is in IDLE. Reset asserted in any state aborts the operation with no response and returns to IDLE.
- **FSM states.** IDLE, REDUCE, FOLD, ISSUE, WAIT, RESP.
- **IDLE.**
  - `req_ready`=1 only in IDLE.
  - On `req_valid` && `req_ready`, latch `func_sel` and `angle_in`, then go to REDUCE.
  - `func_sel`=3: go directly to RESP with `resp_data`=0 and `resp_err`=1.
- **REDUCE (restoring modulo).**
  - Runs for DATA_WIDTH-8 cycles, k from DATA_WIDTH-9 down to 0.
  - Each cycle: if r >= 360<<k, then r -= 360<<k.
  - Result: r = angle mod 360, in 0..359. This step count is fixed and independent of the value.
- **FOLD (one cycle).**
  - Quadrant: q=0 for r<90; q=1 for r<180; q=2 for r<270; else q=3.
  - Folded angle `a`: q0 r; q1 180-r; q2 r-180; q3 360-r.
  - Sign: sin +,+,-,-; cos +,-,-,+; tan +,-,+,-.
  - tan with r=90 or r=270 goes to RESP, skipping ISSUE and WAIT. It returns 0x7FF0000000000000 for r=90 and 0xFFF0000000000000 for r=270, with `resp_err`=1.
- **ISSUE (one cycle).**
  - The selected enable is high for exactly this cycle; the other two enables stay low.
  - `quadrant` and `lut_angle` are valid during ISSUE and held stable until RESP is entered.
- **WAIT.** Counts LUT_LATENCY edges, then captures `lut_data` and goes to RESP.
- **Sign application.**
  - `resp_data` = {sign, `lut_data`[62:0]}.
  - Bit 63 is forced to 0 when `lut_data`[62:0]==0, so no negative zero is produced.
- **RESP.**
  - `resp_valid`=1, with `resp_data` and `resp_err` held stable until `resp_ready`=1 on a rising edge.
  - On that edge: go to IDLE and clear `resp_valid`.
  - No new request is accepted in the same cycle; the next accept happens the cycle after.
- **Latency.** Counted from the accept edge to `resp_valid` high:
  - Normal request: DATA_WIDTH-6+LUT_LATENCY edges (27 for DATA_WIDTH=32, LUT_LATENCY=1).
  - Singular tan: DATA_WIDTH-7 edges (25).
  - Reserved `func_sel`: 1 edge.
- **Input changes.** `angle_in` and `func_sel` changes after acceptance are ignored.

Decomposition:
- **Shared package / defines.**
  - `func_sel` encodings FN_SIN=0, FN_COS=1, FN_TAN=2.
  - FSM state encodings.
  - Constants DEG_90/180/270/360.
  - DBL_POS_INF = 0x7FF0000000000000, DBL_NEG_INF = 0xFFF0000000000000.
- **Sub-module.** `angle_mod360` contains the REDUCE iteration: a shift counter plus compare/subtract, with start and done signals. The FSM, fold, sign logic and handshakes stay in the top-level block.

Test Plan:
- **Sine, basic.** Reset, then sin 30 → `en_sine` pulses once with `lut_angle`=30, `quadrant`=0; `resp_data`=0x3FE0000000000000, `resp_err`=0, `resp_valid` on edge 27.
- **Quadrant signs.**
  - sin 210 → `lut_angle`=30, `quadrant`=2, `resp_data`=0xBFE0000000000000.
  - cos 120 → `lut_angle`=60, `resp_data`=0xBFE0000000000000.
  - tan 135 → `lut_angle`=45, `resp_data`=0xBFF0000000000000.
- **Wrap-around and singularities.**
  - sin 750 → `lut_angle`=30, `resp_data`=0x3FE0000000000000.
  - sin 360 → `lut_angle`=0, `resp_data`=0 with bit 63=0.
  - tan 90 → no enable pulse, `resp_data`=0x7FF0000000000000, `resp_err`=1, `resp_valid` on edge 25.
- **Backpressure.** Hold `resp_ready`=0 for 5 cycles after `resp_valid` while `req_valid` stays high → `resp_data` is stable, `req_ready`=0, and the second request is accepted one cycle after the response handshake.
- **Reset mid-operation.** Assert `reset_n`=0 in REDUCE cycle 10 → outputs return to reset values immediately; `req_ready`=1 after release; a subsequent cos 0 returns 0x3FF0000000000000.
- **Reserved function.** `func_sel`=3 → `resp_valid` 1 edge after accept, `resp_err`=1, `resp_data`=0, no LUT enable.
